// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_slice.sv
// 4-bit ripple-carry adder slice shared by every nibble of the serial add.
module RippleCarryAdder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit slice, LS nibble first, done pulse on completion.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = nibble_count(WIDTH);
  localparam int IDX_W   = $clog2(NIBBLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_q, b_q, acc;
  logic             c_q;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0]    b_load;
  logic                c_load;
  logic [WIDTH-1:0]    acc_next;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                last_nibble;

  // Subtraction is a + ~b + 1, so only the loaded b and carry differ.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  RippleCarryAdder_4bit u_slice (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (c_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the top; after NIBBLES steps acc holds the full sum.
  assign acc_next    = (acc >> NIBBLE_W) | (WIDTH'(slice_sum) << (WIDTH - NIBBLE_W));
  assign last_nibble = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_nibble) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      c_q  <= 1'b0;
      idx  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b_load;
            c_q <= c_load;
            idx <= '0;
          end
        end
        RUN: begin
          a_q <= a_q >> NIBBLE_W;
          b_q <= b_q >> NIBBLE_W;
          acc <= acc_next;
          c_q <= slice_cout;
          idx <= idx + 1'b1;
          if (last_nibble) begin
            sum  <= acc_next;
            cout <= slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed scoreboard bench for serial_add_ctrl (WIDTH=16).
module tb_serial_add_ctrl;

  typedef struct packed {
    logic        c;
    logic [15:0] s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        sub;
  logic        cin;
  logic        busy, done;
  logic [15:0] sum;
  logic        cout;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] prev_sum  = 16'h0;
  logic        prev_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms);
    logic [16:0] r;
`ifdef SERIAL_ADD_SUB_EN
    if (ms) r = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
    else    r = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
`else
    r = {1'b0, ma} + {1'b0, mb} + {16'd0, mc} + 17'(ms & 1'b0);
`endif
    return exp_t'({r[16], r[15:0]});
  endfunction

  // Called at a negedge in IDLE; returns at the negedge right after the start edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    exp_q.push_back(model(ta, tb, tc, ts));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int   n;
    int   busy_cnt;
    exp_t e;
    n = 0;
    busy_cnt = 0;
    forever begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 || n >= 20) break;
      if (n == 2) begin
        check({tag, "_sum_hold"}, 32'(sum), 32'(prev_sum));
        check({tag, "_cout_hold"}, 32'(cout), 32'(prev_cout));
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd4);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e.s));
      check({tag, "_cout"}, 32'(cout), 32'(e.c));
      $display("op %s: sum=0x%04h cout=%0d expected sum=0x%04h cout=%0d",
               tag, sum, cout, e.s, e.c);
      prev_sum  = e.s;
      prev_cout = e.c;
    end
    @(negedge clk);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    check({tag, "_no_extra_done"}, 32'(cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done("add_5555");

    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done("carry_chain");

    start_op(16'h0000, 16'hFFFF, 1'b1, 1'b0);
    wait_done("cin_wrap");

    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done("one_plus_one");

    // start held through RUN/DONE with different operands must not be taken
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(16'h00FF, 16'h0001, 1'b0, 1'b0));
    @(negedge clk);
    a = 16'h1111; b = 16'h2222;
    wait_done("hold_first");
    a = 16'h0A0A; b = 16'h0101;
    exp_q.push_back(model(16'h0A0A, 16'h0101, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    wait_done("hold_second");
    count_done("hold", 6);

    // reset during the second RUN cycle aborts the operation
    start_op(16'h1357, 16'h2468, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    prev_sum = 16'h0; prev_cout = 1'b0;
    count_done("abort", 8);

    start_op(16'hBEEF, 16'h1111, 1'b1, 1'b0);
    wait_done("after_abort");

`ifdef SERIAL_ADD_SUB_EN
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done("sub_borrow");
    start_op(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_done("sub_noborrow");
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-cycle controller that adds two WIDTH-bit operands through a single shared 4-bit ripple-carry adder slice, one nibble per clock, least-significant nibble first. It latches operands on a start handshake and steps the nibble index. It holds the inter-nibble carry in a register and assembles the result, pulsing `done` when the full-width sum and carry-out are valid. It trades latency for area wherever a wide adder is not justified.

## Interface
- `WIDTH`, 16, operand/result width; must be a multiple of 4 and ≥ 4 (elaboration error otherwise).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `a` input WIDTH: operand A; sampled with `start`.
- `b` input WIDTH: operand B; sampled with `start`.
- `cin` input 1: carry-in to nibble 0; sampled with `start`.
- `sub` input 1: subtract select; sampled with `start`. Present only with `SERIAL_ADD_SUB_EN`.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse; result valid.
- `sum` output WIDTH: registered result.
- `cout` output 1: registered carry out of the top nibble.

## Operation
- NIBBLES = WIDTH/4. Internal registers:
  - operand shift registers `a_q`, `b_q`
  - result shift register `acc`
  - carry register `c_q`
  - counter `idx`, width clog2(NIBBLES+1)
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`=1. Load `a_q`=a, `b_q`=b, `c_q`=cin, `idx`=0.
  - RUN, each cycle:
    - Slice inputs: `a_q[3:0]`, `b_q[3:0]`, `c_q`.
    - `a_q`/`b_q` shift right 4.
    - Slice sum shifts into `acc[WIDTH-1:WIDTH-4]`; `acc` shifts right 4.
    - `c_q` ← slice carry; `idx`++.
    - When `idx`=NIBBLES-1, go to DONE. On that same edge, `sum`←final acc and `cout`←final slice carry.
  - DONE→IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored; it is not queued.
- `sum`/`cout` change only on entry to DONE. Outside that edge they hold the last result, so they are stable during the next operation.
- Arithmetic is modulo 2^WIDTH. `cout` is the unsigned carry of a + b + cin.
- Reset (any state, including mid-RUN):
  - state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0
  - `idx`=0, `c_q`=0, `a_q`=`b_q`=`acc`=0
- An aborted operation never produces `done`.

## Timing
- `start` is sampled high at edge k.
  - RUN occupies cycles k..k+NIBBLES-1.
  - `done`=1 during the cycle after edge k+NIBBLES, for exactly one cycle.
- Latency from start edge to `done` high: NIBBLES edges. WIDTH=16 gives 4.
- `busy` rises after edge k and falls after edge k+NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles. The earliest accepted new `start` is sampled in the IDLE cycle after DONE.
- WIDTH=4: RUN lasts one cycle; same rules apply.
- The combinational path is confined to one 4-bit slice plus a mux-free shift. There is no WIDTH-dependent ripple.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - `sub` port exists and is latched at start.
  - When latched `sub`=1, `b_q` loads ~b and `c_q` loads 1. `cin` is ignored.
  - Result: a − b mod 2^WIDTH. `cout`=1 means no borrow (a ≥ b unsigned).
- `SERIAL_ADD_SUB_EN` undefined:
  - No `sub` port.
  - Add-only behaviour exactly as above.

## Structure
- Shared package:
  - FSM state enum (IDLE/RUN/DONE)
  - `NIBBLE_W`=4 constant
  - nibble-count helper function (WIDTH/NIBBLE_W)
- One sub-module: instantiate the existing `RippleCarryAdder_4bit` as the datapath slice.
- FSM, counter, shift registers and output registers live in `serial_add_ctrl`.

## Test plan
All cases use WIDTH=16.
- a=0x1234, b=0x4321, cin=0, start pulse → `done` 4 edges later; `sum`=0x5555, `cout`=0; `busy` high 5 cycles.
- a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1 (carry propagates through all four nibbles via `c_q`).
- a=0x0000, b=0xFFFF, cin=1 → `sum`=0x0000, `cout`=1; then a=0x0001, b=0x0001, cin=0 → `sum`=0x0002, `cout`=0.
- Start 0x00FF+0x0001, then hold `start`=1 with other operands through RUN/DONE:
  - first `done` shows 0x0100.
  - the next accepted start uses operands present in the following IDLE cycle.
  - no extra `done` appears.
- `rst` asserted at the second RUN cycle → next cycle `busy`=0, `done`=0, `sum`=0, `cout`=0; no `done` follows; a new start completes normally.
- With `SERIAL_ADD_SUB_EN`:
  - a=0x0005, b=0x0007, sub=1 → `sum`=0xFFFE, `cout`=0.
  - a=0x0007, b=0x0005, sub=1 → `sum`=0x0002, `cout`=1.
